// File: rtl/pwm_dac_capture_if.sv
// Interface bundling the control inputs and result outputs of pwm_dac_capture.
// The bench drives it through the master modport; the capture block uses the
// slave modport. Clock and reset stay plain ports on the capture block.
interface pwm_dac_capture_if #(
  parameter int SUM_W = 12
);

  logic             enable_i;
  logic             pwm_i;
  logic             sync_i;
  logic [23:0]      dat_o;
  logic [SUM_W-1:0] sum_o;
  logic             valid_o;
  logic             dither_err_o;
  logic             sync_err_o;
  logic             locked_o;

  modport master (
    output enable_i, pwm_i, sync_i,
    input  dat_o, sum_o, valid_o, dither_err_o, sync_err_o, locked_o
  );

  modport slave (
    input  enable_i, pwm_i, sync_i,
    output dat_o, sum_o, valid_o, dither_err_o, sync_err_o, locked_o
  );

endinterface

// File: rtl/pwm_dac_capture.sv
// pwm_dac_capture: samples a looped-back slow-DAC PWM line, measures the high
// time of every period across a 16-period frame and rebuilds the setpoint
// word {base, dither pattern} plus the total high time of the frame.
// Measurement free-runs once aligned to the generator's frame sync; a
// 16-step evaluation stage runs alongside the next frame's measurement.
module pwm_dac_capture #(
  parameter int PERIOD = 156,
  parameter int SUM_W  = 12
) (
  input  logic             adc_clk_i,
  input  logic             adc_rstn_i,
  pwm_dac_capture_if.slave bus
);

  localparam logic [7:0] LAST_PCNT = 8'(PERIOD - 1);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t state_q, state_d;

  // Synchronised inputs
  logic pwm_meta, pwm_s;
  logic sync_meta, sync_s;

  // Measurement accumulators
  logic [7:0]       pcnt_q;
  logic [3:0]       sub_q;
  logic [7:0]       hcnt_q;
  logic [7:0]       min_q;
  logic [SUM_W-1:0] sum_q;
  logic [7:0]       h_q [16];

  // Evaluation stage
  logic             calc_active_q;
  logic [4:0]       calc_k_q;
  logic [7:0]       calc_min_q;
  logic [SUM_W-1:0] calc_sum_q;
  logic [15:0]      pat_q;
  logic             derr_q;

  // Output registers
  logic [23:0]      dat_q;
  logic [SUM_W-1:0] sum_out_q;
  logic             valid_q;
  logic             dither_q;
  logic             sync_err_q;
  logic             locked_q;

  // Per-cycle decode
  logic             meas_en;
  logic             start;
  logic             period_end;
  logic             frame_end;
  logic             sync_bad;
  logic             capture;
  logic [7:0]       h_new;
  logic [7:0]       min_new;
  logic [SUM_W-1:0] sum_new;
  logic [7:0]       h_k;
  logic             pat_k;
  logic             derr_k;

  assign meas_en    = (state_q == MEAS) && bus.enable_i;
  assign start      = (state_q == IDLE) && bus.enable_i && sync_s;
  assign period_end = (pcnt_q == LAST_PCNT);
  assign frame_end  = period_end && (sub_q == 4'd15);
  // A sync anywhere except the last cycle of the frame means we are misaligned.
  assign sync_bad   = meas_en && sync_s && !frame_end;
  assign capture    = meas_en && frame_end;

  assign h_new   = hcnt_q + {7'd0, pwm_s};
  assign min_new = (h_new < min_q) ? h_new : min_q;
  assign sum_new = sum_q + SUM_W'(h_new);

  // Evaluation of one period per step: a period above the minimum is a dither
  // bit; more than one clock above the minimum cannot come from the generator.
  assign h_k    = h_q[calc_k_q[3:0]];
  assign pat_k  = (h_k != calc_min_q);
  assign derr_k = ({1'b0, h_k} > ({1'b0, calc_min_q} + 9'd1));

  // Two-flop synchronisers for the asynchronous PWM and frame-sync lines.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      // NOTE: flops are always written with <=, so every register samples the
      // pre-edge value of the others and simulation matches the hardware.
      pwm_meta  <= 1'b0;
      pwm_s     <= 1'b0;
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      pwm_meta  <= bus.pwm_i;
      pwm_s     <= pwm_meta;
      sync_meta <= bus.sync_i;
      sync_s    <= sync_meta;
    end
  end

  // Frame-alignment state register.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next state: a sync with capture enabled starts measuring; enable low always idles.
  always_comb begin
    // NOTE: the default comes first so every path assigns state_d and no latch
    // is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable_i && sync_s) state_d = MEAS;
      MEAS:    if (!bus.enable_i)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-period high-time measurement, frame accumulation and sync checking.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      pcnt_q     <= '0;
      sub_q      <= '0;
      hcnt_q     <= '0;
      min_q      <= '0;
      sum_q      <= '0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      // NOTE: the 16-entry h array is small register storage, not a RAM, so it
      // takes the async reset like any other flop and starts from a known state.
      for (int i = 0; i < 16; i++) h_q[i] <= '0;
    end else begin
      sync_err_q <= sync_bad;
      if (start || sync_bad) begin
        // Fresh alignment: the cycle after the sync is the first of a frame.
        pcnt_q <= '0;
        sub_q  <= '0;
        hcnt_q <= '0;
        min_q  <= 8'hFF;
        sum_q  <= '0;
        if (sync_bad) locked_q <= 1'b0;
      end else if (meas_en) begin
        if (period_end) begin
          h_q[sub_q] <= h_new;
          pcnt_q     <= '0;
          hcnt_q     <= '0;
          sub_q      <= sub_q + 4'd1;
          if (frame_end) begin
            // Frame totals move to the evaluation stage; restart for the next frame.
            min_q    <= 8'hFF;
            sum_q    <= '0;
            locked_q <= 1'b1;
          end else begin
            min_q <= min_new;
            sum_q <= sum_new;
          end
        end else begin
          pcnt_q <= pcnt_q + 8'd1;
          hcnt_q <= h_new;
        end
      end else begin
        locked_q <= 1'b0;
      end
    end
  end

  // Evaluation stage: 16 steps over the h array, then publish the frame result.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      calc_active_q <= 1'b0;
      calc_k_q      <= '0;
      calc_min_q    <= '0;
      calc_sum_q    <= '0;
      pat_q         <= '0;
      derr_q        <= 1'b0;
      dat_q         <= '0;
      sum_out_q     <= '0;
      valid_q       <= 1'b0;
      dither_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.enable_i) begin
        calc_active_q <= 1'b0;
      end else if (capture) begin
        calc_active_q <= 1'b1;
        calc_k_q      <= '0;
        calc_min_q    <= min_new;
        calc_sum_q    <= sum_new;
        pat_q         <= '0;
        derr_q        <= 1'b0;
      end else if (calc_active_q) begin
        if (calc_k_q == 5'd16) begin
          dat_q         <= {calc_min_q, pat_q};
          sum_out_q     <= calc_sum_q;
          dither_q      <= derr_q;
          valid_q       <= 1'b1;
          calc_active_q <= 1'b0;
        end else begin
          pat_q[calc_k_q[3:0]] <= pat_k;
          if (derr_k) derr_q <= 1'b1;
          calc_k_q <= calc_k_q + 5'd1;
        end
      end
    end
  end

  assign bus.dat_o        = dat_q;
  assign bus.sum_o        = sum_out_q;
  assign bus.valid_o      = valid_q;
  assign bus.dither_err_o = dither_q;
  assign bus.sync_err_o   = sync_err_q;
  assign bus.locked_o     = locked_q;

endmodule
